// File: rtl/ext_int_gateway.sv
// -----------------------------------------------------------------------------
// ext_int_gateway
//
// Platform-side external interrupt source for the core's trap logic. Device
// interrupt lines are synchronized, latched as pending by a per-source
// gateway (level or edge mode), masked by per-source enables and reduced to
// a single external interrupt request. Software services interrupts with a
// claim/complete handshake over a small word-addressed register port.
//
// Register map (addr[3:2]; addr[1:0] ignored), bit i <-> interrupt id i+1:
//   0x0 PENDING  read-only
//   0x4 ENABLE   read/write
//   0x8 EDGE     read/write, 1 = edge-triggered, 0 = level
//   0xC CLAIM    read = claim (returns id, 0 = none), write = complete(id)
// Bits [XLEN-1:SOURCES] read 0 and ignore writes.
//
// Ports:
//   i_clk     core clock, single clock domain
//   i_rst     asynchronous, active-high reset
//   i_src     raw device interrupt lines, asynchronous to i_clk
//   i_addr    byte address of the register access
//   i_wdata   write data
//   i_write   write strobe, one cycle per access
//   i_read    read strobe, one cycle per access (ignored when i_write=1)
//   o_rdata   read data, valid while o_rvalid=1
//   o_rvalid  one-cycle pulse the cycle after an accepted read
//   o_exti    external interrupt request, |(pending & enable)
// -----------------------------------------------------------------------------
module ext_int_gateway #(
  parameter int SOURCES = 8,
  parameter int XLEN    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SOURCES-1:0] i_src,
  input  logic [3:0]         i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  input  logic               i_write,
  input  logic               i_read,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_rvalid,
  output logic               o_exti
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam logic [SOURCES-1:0] ZERO_SRC = {SOURCES{1'b0}};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Lowest set bit index i reported as id i+1; 0 when no bit is set.
  function automatic logic [4:0] f_lowest_id(input logic [SOURCES-1:0] v);
    logic [4:0] id;
    id = 5'd0;
    // Scanning downwards lets the lowest set index overwrite higher ones.
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = 5'(i + 1);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  // One-hot mask for an id in 1..SOURCES; ids 0 and above SOURCES give 0.
  function automatic logic [SOURCES-1:0] f_id_to_mask(input logic [4:0] id);
    logic [SOURCES-1:0] m;
    m = ZERO_SRC;
    for (int i = 0; i < SOURCES; i++) begin
      if (id == 5'(i + 1)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Zero-extend a per-source vector to the register data width.
  function automatic logic [XLEN-1:0] f_zext_src(input logic [SOURCES-1:0] v);
    return {{(XLEN - SOURCES){1'b0}}, v};
  endfunction

  // Zero-extend a 5-bit id to the register data width.
  function automatic logic [XLEN-1:0] f_zext_id(input logic [4:0] id);
    return {{(XLEN - 5){1'b0}}, id};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SOURCES-1:0] r_s1;
  logic [SOURCES-1:0] r_s2;
  logic [SOURCES-1:0] r_s2_d;
  logic [SOURCES-1:0] r_pending;
  logic [SOURCES-1:0] r_in_service;
  logic [SOURCES-1:0] r_enable;
  logic [SOURCES-1:0] r_edge;
  logic [XLEN-1:0]    r_rdata;
  logic               r_rvalid;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]         w_reg_sel;
  logic               w_rd;
  logic               w_claim;
  logic               w_complete;
  logic [SOURCES-1:0] w_eligible;
  logic [4:0]         w_claim_id;
  logic [SOURCES-1:0] w_claim_mask;
  logic [SOURCES-1:0] w_cmpl_mask;
  logic [SOURCES-1:0] w_trigger;
  logic [SOURCES-1:0] w_set;
  logic [SOURCES-1:0] w_pending_nxt;
  logic [SOURCES-1:0] w_in_service_nxt;
  logic [XLEN-1:0]    w_rd_mux;
  logic               w_unused;

  assign w_reg_sel  = i_addr[3:2];
  // A simultaneous write wins; the read is dropped entirely.
  assign w_rd       = i_read & ~i_write;
  assign w_claim    = w_rd & (w_reg_sel == REG_CLAIM);
  assign w_complete = i_write & (w_reg_sel == REG_CLAIM);
  assign w_eligible = r_pending & r_enable;
  assign w_claim_id = f_lowest_id(w_eligible);

  // Bits that carry no function, collected so they are visibly consumed.
  assign w_unused = ^{i_addr[1:0], i_wdata[XLEN-1:SOURCES]};

  // Claim/complete masks and gateway trigger for this edge.
  always_comb begin
    w_claim_mask = ZERO_SRC;
    w_cmpl_mask  = ZERO_SRC;
    if (w_claim) begin
      w_claim_mask = f_id_to_mask(w_claim_id);
    end else begin
      w_claim_mask = ZERO_SRC;
    end
    // Completing an id that is not in service is a no-op.
    if (w_complete) begin
      w_cmpl_mask = f_id_to_mask(i_wdata[4:0]) & r_in_service;
    end else begin
      w_cmpl_mask = ZERO_SRC;
    end
    // Edge mode fires on a synchronized rising edge, level mode on high.
    w_trigger = (r_edge & r_s2 & ~r_s2_d) | (~r_edge & r_s2);
    // The old in_service blocks setting, so a completed level source
    // re-pends one edge after the complete.
    w_set = w_trigger & ~r_in_service;
    // Claim clears after the gateway set, so a claim wins a same-edge set.
    w_pending_nxt    = (r_pending | w_set) & ~w_claim_mask;
    w_in_service_nxt = (r_in_service | w_claim_mask) & ~w_cmpl_mask;
  end

  // Read data source for the selected register.
  always_comb begin
    w_rd_mux = {XLEN{1'b0}};
    case (w_reg_sel)
      REG_PENDING: w_rd_mux = f_zext_src(r_pending);
      REG_ENABLE:  w_rd_mux = f_zext_src(r_enable);
      REG_EDGE:    w_rd_mux = f_zext_src(r_edge);
      REG_CLAIM:   w_rd_mux = f_zext_id(w_claim_id);
      default:     w_rd_mux = {XLEN{1'b0}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= ZERO_SRC;
      r_s2   <= ZERO_SRC;
      r_s2_d <= ZERO_SRC;
    end else begin
      r_s1   <= i_src;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  // Pending and in-service bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending    <= ZERO_SRC;
      r_in_service <= ZERO_SRC;
    end else begin
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_enable <= ZERO_SRC;
      r_edge   <= ZERO_SRC;
    end else if (i_write && (w_reg_sel == REG_ENABLE)) begin
      r_enable <= i_wdata[SOURCES-1:0];
    end else if (i_write && (w_reg_sel == REG_EDGE)) begin
      r_edge <= i_wdata[SOURCES-1:0];
    end else begin
      r_enable <= r_enable;
      r_edge   <= r_edge;
    end
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata  <= {XLEN{1'b0}};
      r_rvalid <= 1'b0;
    end else if (w_rd) begin
      r_rdata  <= w_rd_mux;
      r_rvalid <= 1'b1;
    end else begin
      r_rdata  <= r_rdata;
      r_rvalid <= 1'b0;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  // Straight from registered state: masking takes effect the edge ENABLE changes.
  assign o_exti   = |(r_pending & r_enable);

endmodule
